// File: rtl/fifo_pack_reader_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_pack_reader_if
// Brief     : FWFT FIFO read port plus packed valid/ready output stream.
// Revision  : 1.0
// ============================================================================
interface fifo_pack_reader_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    logic [IN_W-1:0]       fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [IN_W*RATIO-1:0] m_data;
    logic [RATIO-1:0]      m_keep;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_dout, fifo_empty, m_ready,
        output fifo_rd_en, m_data, m_keep, m_last, m_valid
    );

    modport slave (
        output fifo_dout, fifo_empty, m_ready,
        input  fifo_rd_en, m_data, m_keep, m_last, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_pack_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pack_reader
// Brief    : Drains an FWFT FIFO and packs RATIO words per output beat with
//            m_last framing. Optional partial flush: FIFO_FLUSH_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module fifo_pack_reader #(
    parameter int IN_W        = 8,
    parameter int RATIO       = 4,
    parameter int PKT_BEATS   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fifo_pack_reader_if.master bus
);
    localparam int LANE_W = $clog2(RATIO);
    localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int OUT_W  = IN_W * RATIO;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

    generate
        if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || PKT_BEATS < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
            $error("fifo_pack_reader: illegal parameter value");
        end
    endgenerate

    logic [RATIO-2:0][IN_W-1:0] acc_q, acc_d;
    logic [LANE_W-1:0]          lane_cnt_q, lane_cnt_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]           m_data_q, m_data_d;
    logic [RATIO-1:0]           m_keep_q, m_keep_d;
    logic                       m_last_q, m_last_d;
    logic                       m_valid_q, m_valid_d;

    logic out_free;
    logic lane_full;
    logic pop;
    logic accept;

    assign out_free  = ~m_valid_q | bus.m_ready;
    assign lane_full = (lane_cnt_q == LAST_LANE);
    // The completing pop needs a free output slot; earlier lanes never block.
    assign pop       = rst_n & ~bus.fifo_empty & ~(lane_full & ~out_free);
    assign accept    = m_valid_q & bus.m_ready;

`ifdef FIFO_FLUSH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             flush;
    logic [OUT_W-1:0] flush_data;
    logic [RATIO-1:0] flush_keep;

    assign flush = (tmo_q == TMO_MAX) & out_free & ~pop & (lane_cnt_q != '0);

    // Lanes at or above lane_cnt may hold stale words from an earlier beat.
    generate
        for (genvar i = 0; i < RATIO; i++) begin : g_flush_lane
            if (i < RATIO - 1) begin : g_acc_lane
                assign flush_keep[i] = (i < int'(lane_cnt_q));
                assign flush_data[i*IN_W +: IN_W] = flush_keep[i] ? acc_q[i] : '0;
            end else begin : g_top_lane
                assign flush_keep[i] = 1'b0;
                assign flush_data[i*IN_W +: IN_W] = '0;
            end
        end
    endgenerate

    always_comb begin
        tmo_d = tmo_q;
        if (pop || flush || lane_cnt_q == '0) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        acc_d      = acc_q;
        lane_cnt_d = lane_cnt_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q & ~bus.m_ready;
        beat_cnt_d = beat_cnt_q;

        if (accept) begin
            beat_cnt_d = m_last_q ? '0 : beat_cnt_q + BEAT_W'(1);
        end

        if (pop) begin
            if (lane_full) begin
                m_data_d   = {bus.fifo_dout, acc_q};
                m_keep_d   = '1;
                m_last_d   = (beat_cnt_d == LAST_BEAT);
                m_valid_d  = 1'b1;
                lane_cnt_d = '0;
            end else begin
                acc_d[lane_cnt_q] = bus.fifo_dout;
                lane_cnt_d        = lane_cnt_q + LANE_W'(1);
            end
        end
`ifdef FIFO_FLUSH_TIMEOUT_EN
        else if (flush) begin
            m_data_d   = flush_data;
            m_keep_d   = flush_keep;
            m_last_d   = 1'b1;
            m_valid_d  = 1'b1;
            lane_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            lane_cnt_q <= '0;
            beat_cnt_q <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            lane_cnt_q <= lane_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;
    assign bus.m_last     = m_last_q;
    assign bus.m_valid    = m_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_reader.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for fifo_pack_reader: a FIFO model feeds two instances
// (PKT_BEATS=4 and PKT_BEATS=1) and accepted beats are collected per instance.
module tb_fifo_pack_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_pack_reader_if #(.IN_W(8), .RATIO(4)) bus0 ();
    fifo_pack_reader_if #(.IN_W(8), .RATIO(4)) bus1 ();

    fifo_pack_reader #(.IN_W(8), .RATIO(4), .PKT_BEATS(4), .TIMEOUT_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    fifo_pack_reader #(.IN_W(8), .RATIO(4), .PKT_BEATS(1), .TIMEOUT_CYC(16)) u_dut_p1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [31:0] rx0_data[$];
    logic [3:0]  rx0_keep[$];
    logic        rx0_last[$];
    logic [31:0] rx1_data[$];
    logic        rx1_last[$];
    logic        last_pop0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic upd_fifo();
        bus0.fifo_empty = (q0.size() == 0);
        bus0.fifo_dout  = (q0.size() != 0) ? q0[0] : 8'h00;
        bus1.fifo_empty = (q1.size() == 0);
        bus1.fifo_dout  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic tick();
        logic p0, p1, a0, a1, l0, l1;
        logic [31:0] d0, d1;
        logic [3:0] k0;
        #1;
        p0 = bus0.fifo_rd_en;  p1 = bus1.fifo_rd_en;
        a0 = bus0.m_valid & bus0.m_ready;  a1 = bus1.m_valid & bus1.m_ready;
        d0 = bus0.m_data;  k0 = bus0.m_keep;  l0 = bus0.m_last;
        d1 = bus1.m_data;  l1 = bus1.m_last;
        @(posedge clk);
        #1;
        last_pop0 = p0;
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        if (a0) begin rx0_data.push_back(d0); rx0_keep.push_back(k0); rx0_last.push_back(l0); end
        if (a1) begin rx1_data.push_back(d1); rx1_last.push_back(l1); end
        upd_fifo();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus0.m_ready = 1'b0;
        bus1.m_ready = 1'b0;
        q0.delete(); q1.delete();
        upd_fifo();
        tick(); tick();
        rst_n = 1'b1;
        rx0_data.delete(); rx0_keep.delete(); rx0_last.delete();
        rx1_data.delete(); rx1_last.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q0.push_back(8'h11);
        upd_fifo();
        tick(); tick();
        n_total++; if (bus0.m_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus0.m_valid); else n_pass++;
        n_total++; if (bus0.m_last !== 1'b0) $display("FAIL rst_last: got %b expected 0", bus0.m_last); else n_pass++;
        n_total++; if (bus0.m_data !== 32'h0) $display("FAIL rst_data: got %h expected 00000000", bus0.m_data); else n_pass++;
        n_total++; if (bus0.m_keep !== 4'h0) $display("FAIL rst_keep: got %h expected 0", bus0.m_keep); else n_pass++;
        n_total++; if (bus0.fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", bus0.fifo_rd_en); else n_pass++;
        rst_n = 1'b1;
        bus0.m_ready = 1'b1;
        q0.push_back(8'h22);
        upd_fifo();
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++; if (bus0.m_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", bus0.m_valid); else n_pass++;
        for (int i = 0; i < 4; i++) q0.push_back(8'hA0 + 8'(i));
        upd_fifo();
        repeat (8) tick();
        n_total++; if (rx0_data.size() !== 1) $display("FAIL midrst_count: got %0d expected 1", rx0_data.size()); else n_pass++;
        n_total++;
        if (((rx0_data.size() > 0) ? rx0_data[0] : 32'hx) !== 32'hA3A2A1A0)
            $display("FAIL midrst_data: got %h expected a3a2a1a0", (rx0_data.size() > 0) ? rx0_data[0] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_stream();
        int pops = 0;
        logic [31:0] exp_d;
        apply_reset();
        bus0.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) q0.push_back(8'(i));
        upd_fifo();
        repeat (16) begin tick(); if (last_pop0) pops++; end
        repeat (4) tick();
        n_total++; if (pops !== 16) $display("FAIL stream_pops: got %0d expected 16", pops); else n_pass++;
        n_total++; if (rx0_data.size() !== 4) $display("FAIL stream_count: got %0d expected 4", rx0_data.size()); else n_pass++;
        for (int b = 0; b < 4 && b < rx0_data.size(); b++) begin
            exp_d = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
            n_total++; if (rx0_data[b] !== exp_d) $display("FAIL stream_data%0d: got %h expected %h", b, rx0_data[b], exp_d); else n_pass++;
            n_total++; if (rx0_last[b] !== (b == 3)) $display("FAIL stream_last%0d: got %b expected %b", b, rx0_last[b], (b == 3)); else n_pass++;
            n_total++; if (rx0_keep[b] !== 4'hF) $display("FAIL stream_keep%0d: got %h expected f", b, rx0_keep[b]); else n_pass++;
        end
        n_total++; if (bus0.fifo_rd_en !== 1'b0) $display("FAIL stream_empty_rd: got %b expected 0", bus0.fifo_rd_en); else n_pass++;
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int chg = 0;
        logic seen = 1'b0;
        logic [31:0] held = '0;
        apply_reset();
        for (int i = 0; i < 8; i++) q0.push_back(8'h10 + 8'(i));
        upd_fifo();
        repeat (12) begin
            tick();
            if (last_pop0) pops++;
            if (bus0.m_valid && seen && bus0.m_data !== held) chg++;
            if (bus0.m_valid && !seen) begin seen = 1'b1; held = bus0.m_data; end
        end
        n_total++; if (pops !== 7) $display("FAIL bp_pops: got %0d expected 7", pops); else n_pass++;
        n_total++; if (chg !== 0) $display("FAIL bp_stable: got %0d changes expected 0", chg); else n_pass++;
        n_total++; if (bus0.m_data !== 32'h13121110) $display("FAIL bp_held: got %h expected 13121110", bus0.m_data); else n_pass++;
        n_total++; if (bus0.fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b expected 0", bus0.fifo_rd_en); else n_pass++;
        n_total++; if (q0.size() !== 1) $display("FAIL bp_left: got %0d expected 1", q0.size()); else n_pass++;
        bus0.m_ready = 1'b1;
        tick();
        n_total++; if (bus0.m_valid !== 1'b1) $display("FAIL bp_b2b_valid: got %b expected 1", bus0.m_valid); else n_pass++;
        n_total++; if (bus0.m_data !== 32'h17161514) $display("FAIL bp_b2b_data: got %h expected 17161514", bus0.m_data); else n_pass++;
        tick(); tick();
        n_total++; if (rx0_data.size() !== 2) $display("FAIL bp_count: got %0d expected 2", rx0_data.size()); else n_pass++;
        n_total++;
        if (((rx0_data.size() > 1) ? rx0_data[1] : 32'hx) !== 32'h17161514)
            $display("FAIL bp_second: got %h expected 17161514", (rx0_data.size() > 1) ? rx0_data[1] : 32'hx);
        else n_pass++;
        n_total++; if (bus0.m_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", bus0.m_valid); else n_pass++;
    endtask

`ifndef FIFO_FLUSH_TIMEOUT_EN
    task automatic test_empty_stall();
        int vcnt = 0;
        apply_reset();
        bus0.m_ready = 1'b1;
        q0.push_back(8'h01); q0.push_back(8'h02);
        upd_fifo();
        tick(); tick();
        repeat (50) begin tick(); if (bus0.m_valid) vcnt++; end
        n_total++; if (vcnt !== 0) $display("FAIL stall_valid: got %0d cycles expected 0", vcnt); else n_pass++;
        q0.push_back(8'h03); q0.push_back(8'h04);
        upd_fifo();
        repeat (4) tick();
        n_total++; if (rx0_data.size() !== 1) $display("FAIL stall_count: got %0d expected 1", rx0_data.size()); else n_pass++;
        n_total++;
        if (((rx0_data.size() > 0) ? rx0_data[0] : 32'hx) !== 32'h04030201)
            $display("FAIL stall_data: got %h expected 04030201", (rx0_data.size() > 0) ? rx0_data[0] : 32'hx);
        else n_pass++;
        n_total++;
        if (((rx0_keep.size() > 0) ? rx0_keep[0] : 4'hx) !== 4'hF)
            $display("FAIL stall_keep: got %h expected f", (rx0_keep.size() > 0) ? rx0_keep[0] : 4'hx);
        else n_pass++;
    endtask
`else
    task automatic test_timeout();
        int n = 0;
        int bad_last = 0;
        apply_reset();
        q0.push_back(8'h55); q0.push_back(8'h66);
        upd_fifo();
        tick(); tick();
        while (!bus0.m_valid && n < 40) begin tick(); n++; end
        n_total++; if (n !== 17) $display("FAIL tmo_delay: got %0d expected 17", n); else n_pass++;
        n_total++; if (bus0.m_data !== 32'h00006655) $display("FAIL tmo_data: got %h expected 00006655", bus0.m_data); else n_pass++;
        n_total++; if (bus0.m_keep !== 4'h3) $display("FAIL tmo_keep: got %h expected 3", bus0.m_keep); else n_pass++;
        n_total++; if (bus0.m_last !== 1'b1) $display("FAIL tmo_last: got %b expected 1", bus0.m_last); else n_pass++;
        for (int i = 0; i < 16; i++) q0.push_back(8'h80 + 8'(i));
        bus0.m_ready = 1'b1;
        upd_fifo();
        repeat (24) tick();
        n_total++; if (rx0_data.size() !== 5) $display("FAIL tmo_count: got %0d expected 5", rx0_data.size()); else n_pass++;
        for (int b = 1; b < rx0_last.size(); b++) if (rx0_last[b] !== (b == 4)) bad_last++;
        n_total++; if (bad_last !== 0) $display("FAIL tmo_framing: got %0d bad m_last expected 0", bad_last); else n_pass++;
        n_total++;
        if (((rx0_data.size() > 1) ? rx0_data[1] : 32'hx) !== 32'h83828180)
            $display("FAIL tmo_next: got %h expected 83828180", (rx0_data.size() > 1) ? rx0_data[1] : 32'hx);
        else n_pass++;
    endtask
`endif

    task automatic test_pkt_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [31:0] exp_d;
        int n = 0;
        int nonlast = 0;
        int mism = 0;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            q1.push_back(b);
            exp_q.push_back(b);
        end
        upd_fifo();
        while (rx1_data.size() < 16 && n < 1000) begin
            bus1.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus1.m_ready = 1'b0;
        n_total++; if (rx1_data.size() !== 16) $display("FAIL wrap_count: got %0d expected 16", rx1_data.size()); else n_pass++;
        for (int i = 0; i < rx1_data.size(); i++) begin
            if (rx1_last[i] !== 1'b1) nonlast++;
            exp_d = {exp_q[4*i+3], exp_q[4*i+2], exp_q[4*i+1], exp_q[4*i]};
            if (rx1_data[i] !== exp_d) mism++;
        end
        n_total++; if (nonlast !== 0) $display("FAIL wrap_last: got %0d beats without m_last expected 0", nonlast); else n_pass++;
        n_total++; if (mism !== 0) $display("FAIL wrap_order: got %0d wrong beats expected 0", mism); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.m_ready = 1'b0;
        bus1.m_ready = 1'b0;
        last_pop0 = 1'b0;
        upd_fifo();
        test_reset();
        test_stream();
        test_backpressure();
`ifndef FIFO_FLUSH_TIMEOUT_EN
        test_empty_stall();
`else
        test_timeout();
`endif
        test_pkt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end
endmodule
`default_nettype wire

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
Read-side stage that drains a first-word-fall-through sync FIFO and packs RATIO consecutive narrow words into one wide beat. Beats are presented on a valid/ready master stream with packet framing.
- m_last is asserted every PKT_BEATS beats.
- Sits directly downstream of the team's sync FIFO, driving its rd_en from its empty flag and fall-through dout.

Parameters:
IN_W, 8, width of FIFO data word
RATIO, 4, narrow words per output beat; power of 2, >=2
PKT_BEATS, 4, output beats per packet (m_last period); >=1
TIMEOUT_CYC, 16, idle cycles before partial flush (used only with FIFO_FLUSH_TIMEOUT_EN); >=1

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
fifo_dout  in  IN_W  FWFT data from FIFO; valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  pop strobe to FIFO
m_data  out  IN_W*RATIO  packed beat; lane 0 = [IN_W-1:0]
m_keep  out  RATIO  per-lane valid mask
m_last  out  1  last beat of packet
m_valid  out  1  beat valid
m_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync deassert by clk): m_valid=0, m_last=0, m_data=0, m_keep=0. Lane counter, beat counter and timeout counter all 0. Any partial pack is discarded. fifo_rd_en=0 combinationally while rst_n=0.
- out_free = ~m_valid | m_ready.
- Pop rule: fifo_rd_en = ~fifo_empty & ~(lane_cnt==RATIO-1 & ~out_free). This is combinational; never assert rd_en while fifo_empty=1.
- On pop: fifo_dout is written to acc lane lane_cnt, and lane_cnt increments.
- Beat completion: the pop at lane_cnt==RATIO-1 loads {fifo_dout, acc lanes RATIO-2..0} into m_data on the same edge.
  - m_keep = all ones, m_valid=1, lane_cnt wraps to 0.
  - Latency: the completing pop at edge t gives m_valid=1 after edge t.
- First word popped goes to lane 0 (LSB); ordering is strictly FIFO order.
- Handshake:
  - m_data, m_keep and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid drops after the accepting edge unless a new beat loads on that same edge (back-to-back allowed).
- Throughput: one pop per cycle while data is available and out_free. Sustained one beat per RATIO cycles.
- Framing:
  - beat_cnt counts accepted beats, 0..PKT_BEATS-1.
  - m_last = (beat_cnt==PKT_BEATS-1) for the beat being presented.
  - beat_cnt wraps to 0 after the m_last beat is accepted.
  - With PKT_BEATS=1, m_last is always 1.
- Stall boundary: when the acc holds RATIO-1 words and the output is blocked, fifo_rd_en=0. No data is lost or overwritten.
- FIFO empty mid-beat: the partial acc is held indefinitely (unless the optional feature is enabled). lane_cnt is unchanged.

Optional Feature:
FIFO_FLUSH_TIMEOUT_EN
- Defined:
  - A timeout counter increments each cycle lane_cnt!=0 with no pop. It clears on any pop, and saturates at TIMEOUT_CYC.
  - When the count equals TIMEOUT_CYC and out_free=1 (and no pop occurs that cycle), the partial acc is loaded as a beat:
    - filled lanes carry their data; unfilled lanes are 0;
    - m_keep has ones in lanes 0..lane_cnt-1 only;
    - m_last is forced to 1;
    - on acceptance, beat_cnt resets to 0; lane_cnt and the timeout counter clear at load.
- Undefined: no timeout logic is present, m_keep is constant all-ones whenever m_valid=1, and partial words wait for completion.

Test Plan:
Defaults apply (IN_W=8, RATIO=4, PKT_BEATS=4) unless stated otherwise.
1. Reset mid-beat: pop 0x11,0x22, assert rst_n=0 for 1 cycle, then pop 0xA0..0xA3 -> one beat m_data=0xA3A2A1A0; stale words never appear.
2. Streaming: FIFO holds 0x00..0x0F, m_ready=1 -> 4 beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; m_last=1 on 4th only; fifo_rd_en high 16 consecutive cycles.
3. Backpressure: m_ready=0 with 8 words queued -> first beat held stable, exactly 7 pops then rd_en=0. Raising m_ready -> second beat follows the next cycle; no loss or duplication.
4. Empty stall: FIFO supplies 0x01,0x02, then is empty for 50 cycles (macro off), then supplies 0x03,0x04 -> single beat 0x04030201, m_keep=0xF.
5. Timeout (macro on, TIMEOUT_CYC=16): pop 0x55,0x66, then FIFO empty -> 16 idle cycles later m_valid=1, m_data=0x00006655, m_keep=0x3, m_last=1. The next full beat has beat_cnt=0.
6. Packet wrap, PKT_BEATS=1 and random m_ready over 64 words -> every beat m_last=1; data order matches the FIFO scoreboard.
